// File: rtl/cache_miss_controller.sv
// Miss sequencer for a direct-mapped write-back cache. Owns the tag/valid/dirty store and
// drives the data array and main memory for dirty-line write-back and line refill.
module cache_miss_controller #(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic                            cpu_ready,
  output logic [DATA_W-1:0]               cpu_rdata,
  output logic [INDEX_W+OFFSET_W-1:0]     da_addr,
  output logic                            da_we,
  output logic [DATA_W-1:0]               da_wdata,
  input  logic [DATA_W-1:0]               da_rdata,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic                            mem_ack,
  input  logic [DATA_W-1:0]               mem_rdata
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
  localparam int DA_W   = INDEX_W + OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_RD, WB_WR, REFILL, REISSUE} state_t;

  state_t                state, state_n;
  logic [OFFSET_W-1:0]   k, k_n;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_we;
  logic [DATA_W-1:0]     req_wdata;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic [LINES-1:0]      valid_q, dirty_q;

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag, old_tag;
  logic [OFFSET_W-1:0]   off;
  logic                  hit, set_dirty, fill_done;

  assign idx     = req_addr[OFFSET_W +: INDEX_W];
  assign tag     = req_addr[ADDR_W-1 -: TAG_W];
  assign off     = req_addr[OFFSET_W-1:0];
  assign old_tag = tag_mem[idx];
  assign hit     = valid_q[idx] && (old_tag == tag);

  always_comb begin
    state_n   = state;
    k_n       = k;
    da_addr   = '0;
    da_we     = 1'b0;
    da_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    set_dirty = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        da_addr = cpu_addr[DA_W-1:0];
        if (cpu_req) state_n = LOOKUP;
      end
      LOOKUP: begin
        da_addr = {idx, off};
        if (hit) begin
          if (req_we) begin
            da_we     = 1'b1;
            da_wdata  = req_wdata;
            set_dirty = 1'b1;
          end
          state_n = IDLE;
        end else begin
          k_n     = '0;
          state_n = (valid_q[idx] && dirty_q[idx]) ? WB_RD : REFILL;
        end
      end
      WB_RD: begin
        da_addr = {idx, k};
        state_n = WB_WR;
      end
      WB_WR: begin
        // da_addr stays on the word so da_rdata holds while memory stalls
        da_addr   = {idx, k};
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {old_tag, idx, k};
        mem_wdata = da_rdata;
        if (mem_ack) begin
          k_n     = k + 1'b1;
          state_n = (&k) ? REFILL : WB_RD;
        end
      end
      REFILL: begin
        da_addr  = {idx, k};
        mem_req  = 1'b1;
        mem_addr = {tag, idx, k};
        if (mem_ack) begin
          da_we    = 1'b1;
          da_wdata = mem_rdata;
          k_n      = k + 1'b1;
          if (&k) begin
            fill_done = 1'b1;
            state_n   = REISSUE;
          end
        end
      end
      REISSUE: begin
        da_addr = {idx, off};
        state_n = LOOKUP;
      end
      default: state_n = IDLE;
    endcase
    // Reset silences the array and memory ports in the same cycle it is seen
    if (reset) begin
      da_addr   = '0;
      da_we     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      set_dirty = 1'b0;
      fill_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cpu_ready <= (state == LOOKUP) && hit;
      if (state == IDLE && cpu_req) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
      end
      if (state == LOOKUP && hit && !req_we) cpu_rdata <= da_rdata;
      if (set_dirty) dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag store needs no reset: valid_q gates every use
  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[idx] <= tag;
  end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller with a sync-read data array model and a
// word-handshake memory that returns its own address and acks after a random delay.
module tb_cache_miss_controller;
  logic        clk = 0, reset = 1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [16:0] cpu_addr = 17'h1ABCD;
  logic [31:0] cpu_wdata = 0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [13:0] da_addr;
  logic        da_we;
  logic [31:0] da_wdata, da_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  cache_miss_controller dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .da_addr(da_addr), .da_we(da_we), .da_wdata(da_wdata), .da_rdata(da_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  logic [31:0] darr [16384];
  initial for (int i = 0; i < 16384; i++) darr[i] = '0;
  always @(posedge clk) begin
    da_rdata <= darr[da_addr];
    if (da_we) darr[da_addr] <= da_wdata;
  end

  int max_dly = 0, dly = 0, wcnt = 0;
  assign mem_rdata = {15'b0, mem_addr};
  assign mem_ack   = mem_req && (wcnt >= dly);
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      wcnt <= 0;
      dly  <= int'($urandom_range(0, max_dly));
    end else if (mem_req) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  logic [16:0] wr_a [1024], rd_a [1024];
  logic [31:0] wr_d [1024];
  int wr_n = 0, rd_n = 0, stab_err = 0;
  logic        pend = 0, p_we = 0;
  logic [16:0] p_addr = 0;
  logic [31:0] p_wdata = 0;
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        if (wr_n < 1024) begin wr_a[wr_n] = mem_addr; wr_d[wr_n] = mem_wdata; end
        wr_n++;
      end else begin
        if (rd_n < 1024) rd_a[rd_n] = mem_addr;
        rd_n++;
      end
    end
    if (pend && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      stab_err++;
    if (mem_req && mem_we && da_we) stab_err++;
    pend    <= mem_req && !mem_ack;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
  end

  int total = 0, pass = 0;

  task automatic do_req(input logic we, input logic [16:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rd);
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cpu_ready && cyc < 2000);
    rd = cpu_rdata;
    cpu_req = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cpu_addr = 17'h1ABCD;
    repeat (3) @(negedge clk);
    total++;
    if ({cpu_ready, cpu_rdata} !== 33'h0) $display("FAIL reset_cpu: got %h want 0", {cpu_ready, cpu_rdata});
    else pass++;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 51'h0)
      $display("FAIL reset_mem: got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata});
    else pass++;
    total++;
    if ({da_we, da_addr} !== 15'h0) $display("FAIL reset_da: got %h want 0", {da_we, da_addr});
    else pass++;
    reset = 0;
  endtask

  task automatic test_clean_miss();
    int cyc, r0, w0; logic [31:0] rd; logic bad;
    r0 = rd_n; w0 = wr_n;
    do_req(0, 17'h1380B, 0, cyc, rd);
    total++;
    if (cyc !== 20) $display("FAIL clean_miss_cycles: got %0d want 20", cyc); else pass++;
    total++;
    if (rd !== 32'h0001380B) $display("FAIL clean_miss_rdata: got %h want 0001380b", rd); else pass++;
    total++;
    if (rd_n - r0 !== 16 || wr_n - w0 !== 0)
      $display("FAIL clean_miss_counts: got rd %0d wr %0d want 16 0", rd_n - r0, wr_n - w0);
    else pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) if (rd_a[r0+i] !== 17'h13800 + 17'(i)) bad = 1;
    total++;
    if (bad) $display("FAIL clean_miss_seq: got first %h want 13800..1380f", rd_a[r0]); else pass++;
  endtask

  task automatic test_write_hit();
    int cyc, r0, w0; logic [31:0] rd;
    r0 = rd_n; w0 = wr_n;
    do_req(1, 17'h1380B, 32'h0C0C0C0C, cyc, rd);
    total++;
    if (cyc !== 2) $display("FAIL write_hit_cycles: got %0d want 2", cyc); else pass++;
    do_req(0, 17'h1380B, 0, cyc, rd);
    total++;
    if (rd !== 32'h0C0C0C0C || cyc !== 2)
      $display("FAIL read_hit: got %h/%0d want 0c0c0c0c/2", rd, cyc);
    else pass++;
    total++;
    if (rd_n !== r0 || wr_n !== w0) $display("FAIL hit_no_mem: got %0d handshakes want 0", rd_n - r0 + wr_n - w0);
    else pass++;
  endtask

  task automatic test_dirty_miss();
    int cyc, r0, w0; logic [31:0] rd; logic bad;
    r0 = rd_n; w0 = wr_n;
    do_req(0, 17'h1F80B, 0, cyc, rd);
    total++;
    if (cyc !== 52) $display("FAIL dirty_miss_cycles: got %0d want 52", cyc); else pass++;
    total++;
    if (rd !== 32'h0001F80B) $display("FAIL dirty_miss_rdata: got %h want 0001f80b", rd); else pass++;
    total++;
    if (rd_n - r0 !== 16 || wr_n - w0 !== 16)
      $display("FAIL dirty_miss_counts: got rd %0d wr %0d want 16 16", rd_n - r0, wr_n - w0);
    else pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_a[w0+i] !== 17'h13800 + 17'(i)) bad = 1;
      if (wr_d[w0+i] !== ((i == 11) ? 32'h0C0C0C0C : 32'h00013800 + i)) bad = 1;
      if (rd_a[r0+i] !== 17'h1F800 + 17'(i)) bad = 1;
    end
    total++;
    if (bad) $display("FAIL dirty_miss_seq: got wb word b %h want 0c0c0c0c", wr_d[w0+11]); else pass++;
  endtask

  task automatic test_write_allocate();
    int cyc, r0, w0; logic [31:0] rd; logic bad;
    r0 = rd_n; w0 = wr_n;
    do_req(1, 17'h1780B, 32'h0A0A0A0A, cyc, rd);
    total++;
    if (cyc !== 20 || rd_n - r0 !== 16 || wr_n - w0 !== 0 || rd_a[r0] !== 17'h17800)
      $display("FAIL wr_alloc: got cyc %0d rd %0d wr %0d want 20 16 0", cyc, rd_n - r0, wr_n - w0);
    else pass++;
    do_req(0, 17'h1780B, 0, cyc, rd);
    total++;
    if (rd !== 32'h0A0A0A0A || cyc !== 2) $display("FAIL wr_alloc_read: got %h/%0d want 0a0a0a0a/2", rd, cyc);
    else pass++;
    r0 = rd_n; w0 = wr_n;
    do_req(0, 17'h1380B, 0, cyc, rd);
    total++;
    if (rd !== 32'h0001380B || cyc !== 52) $display("FAIL wr_alloc_evict: got %h/%0d want 0001380b/52", rd, cyc);
    else pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_a[w0+i] !== 17'h17800 + 17'(i)) bad = 1;
      if (wr_d[w0+i] !== ((i == 11) ? 32'h0A0A0A0A : 32'h00017800 + i)) bad = 1;
    end
    total++;
    if (bad || wr_n - w0 !== 16) $display("FAIL wr_alloc_wb: got word b %h want 0a0a0a0a", wr_d[w0+11]);
    else pass++;
  endtask

  task automatic test_ack_delay_and_reset();
    int cyc, r0, w0, n; logic [31:0] rd; logic bad;
    max_dly = 3;
    stab_err = 0;
    do_req(1, 17'h0002A, 32'h55555555, cyc, rd);
    r0 = rd_n; w0 = wr_n;
    do_req(0, 17'h1402A, 0, cyc, rd);
    total++;
    if (rd !== 32'h0001402A || cyc >= 2000) $display("FAIL delay_rdata: got %h/%0d want 0001402a", rd, cyc);
    else pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_a[w0+i] !== 17'h00020 + 17'(i)) bad = 1;
      if (wr_d[w0+i] !== ((i == 10) ? 32'h55555555 : 32'h00000020 + i)) bad = 1;
      if (rd_a[r0+i] !== 17'h14020 + 17'(i)) bad = 1;
    end
    total++;
    if (bad || rd_n - r0 !== 16 || wr_n - w0 !== 16)
      $display("FAIL delay_seq: got rd %0d wr %0d want 16 16", rd_n - r0, wr_n - w0);
    else pass++;
    total++;
    if (stab_err !== 0) $display("FAIL delay_stable: got %0d violations want 0", stab_err); else pass++;
    // Abort a refill part way through
    r0 = rd_n;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 17'h0A0B5;
    n = 0;
    while (!(rd_n - r0 >= 3 && mem_req && !mem_we) && n < 300) begin @(negedge clk); n++; end
    total++;
    if (n >= 300) $display("FAIL abort_reach_refill: got timeout want refill"); else pass++;
    cpu_req = 0;
    reset = 1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0) $display("FAIL abort_mem_req: got %b want 0", mem_req); else pass++;
    reset = 0;
    max_dly = 0;
    @(negedge clk);
    r0 = rd_n; w0 = wr_n;
    do_req(0, 17'h1380B, 0, cyc, rd);
    total++;
    if (rd !== 32'h0001380B || rd_n - r0 !== 16 || wr_n - w0 !== 0)
      $display("FAIL abort_then_miss: got %h rd %0d wr %0d want 0001380b 16 0", rd, rd_n - r0, wr_n - w0);
    else pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, r0; logic [31:0] rd;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 17'h1380B;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cpu_ready && cyc < 100);
    rd = cpu_rdata;
    cpu_we = 1; cpu_addr = 17'h13805; cpu_wdata = 32'h66666666;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cpu_ready && cyc < 100);
    cpu_req = 0;
    total++;
    if (rd !== 32'h0001380B || cyc !== 2)
      $display("FAIL held_req: got %h/%0d want 0001380b/2", rd, cyc);
    else pass++;
    total++;
    if (cpu_rdata !== 32'h0001380B) $display("FAIL rdata_held: got %h want 0001380b", cpu_rdata); else pass++;
    do_req(0, 17'h13805, 0, cyc, rd);
    total++;
    if (rd !== 32'h66666666) $display("FAIL held_write_data: got %h want 66666666", rd); else pass++;
    // Request wiggles while busy must not disturb the accepted miss
    r0 = rd_n;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 17'h0E0C7;
    @(negedge clk);
    cyc = 1;
    for (int i = 0; i < 8; i++) begin
      cpu_req = i[0]; cpu_we = 1; cpu_addr = 17'($urandom);
      @(negedge clk); cyc++;
    end
    cpu_req = 0; cpu_we = 0; cpu_addr = 17'h0E0C7;
    while (!cpu_ready && cyc < 200) begin @(negedge clk); cyc++; end
    total++;
    if (cpu_rdata !== 32'h0000E0C7 || cyc !== 20 || rd_n - r0 !== 16)
      $display("FAIL busy_ignore: got %h/%0d/%0d want 0000e0c7/20/16", cpu_rdata, cyc, rd_n - r0);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_write_allocate();
    test_ack_delay_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
